// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with per-state strobes/selects.
// Latency: outputs are combinational decodes of state+IR fields; 2..5+w cycles per instruction.
// Backpressure: stalls in MEM until dmem_ack, aborts after WAIT_MAX non-ack cycles. Option: MC_CTRL_PERF_EN adds counters.
module mc_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        dmem_ack,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RegWr,
    output logic        MemWr,
    output logic        dmem_req,
    output logic        ExtOp,
    output logic        ALUSrc,
    output logic [2:0]  ALUOp,
    output logic [1:0]  RegDst,
    output logic [1:0]  WDSel,
    output logic [1:0]  NPCOp,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        mem_err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instr_cnt,
    output logic [31:0] cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } stateT;

    stateT      curState;
    stateT      nextState;
    logic [7:0] waitCnt;
    logic       lastWait;

    logic isR, isAddu, isSubu, isJr, isNop, isOri, isLui, isLw, isSw, isBeq, isJ, isJal;

    // Instruction class decode from the latched IR fields
    always_comb begin
        isR    = (opcode == 6'h00);
        isAddu = isR && (funct == 6'h21);
        isSubu = isR && (funct == 6'h23);
        isJr   = isR && (funct == 6'h08);
        isNop  = isR && (funct == 6'h00);
        isOri  = (opcode == 6'h0d);
        isLui  = (opcode == 6'h0f);
        isLw   = (opcode == 6'h23);
        isSw   = (opcode == 6'h2b);
        isBeq  = (opcode == 6'h04);
        isJ    = (opcode == 6'h02);
        isJal  = (opcode == 6'h03);
    end

    // The WAIT_MAX-th consecutive non-ack MEM cycle is the abort cycle
    assign lastWait = (waitCnt == 8'(WAIT_MAX - 1));

    // State register; reset returns straight to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) curState <= FETCH;
        else        curState <= nextState;
    end

    // MEM wait counter: counts non-ack cycles, cleared whenever MEM is left
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    waitCnt <= 8'd0;
        else if (curState == MEM && nextState == MEM)  waitCnt <= waitCnt + 8'd1;
        else                                           waitCnt <= 8'd0;
    end

    // Next state and Moore-style strobes/selects; everything held at 0 while in reset
    always_comb begin
        nextState = curState;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        RegWr     = 1'b0;
        MemWr     = 1'b0;
        dmem_req  = 1'b0;
        ExtOp     = 1'b0;
        ALUSrc    = 1'b0;
        ALUOp     = 3'd0;
        RegDst    = 2'd0;
        WDSel     = 2'd0;
        NPCOp     = 2'd0;
        illegal   = 1'b0;
        mem_err   = 1'b0;
        if (reset) begin
            // ALU/extender selects stay valid for the whole EXEC..WB span
            if (curState == EXEC || curState == MEM || curState == WB) begin
                ExtOp  = isLw || isSw || isBeq;
                ALUSrc = isOri || isLui || isLw || isSw;
                if (isSubu || isBeq) ALUOp = 3'd1;
                else if (isOri)      ALUOp = 3'd2;
                else if (isLui)      ALUOp = 3'd3;
                else                 ALUOp = 3'd0;
            end
            case (curState)
                FETCH: begin
                    IRWr      = 1'b1;
                    PCWr      = 1'b1;
                    nextState = DECODE;
                end
                DECODE: begin
                    nextState = FETCH;
                    if (isJ) begin
                        PCWr  = 1'b1;
                        NPCOp = 2'd2;
                    end else if (isJal) begin
                        PCWr   = 1'b1;
                        NPCOp  = 2'd2;
                        RegWr  = 1'b1;
                        RegDst = 2'd2;
                        WDSel  = 2'd2;
                    end else if (isJr) begin
                        PCWr  = 1'b1;
                        NPCOp = 2'd3;
                    end else if (isNop) begin
                        nextState = FETCH;
                    end else if (isAddu || isSubu || isOri || isLui || isLw || isSw || isBeq) begin
                        nextState = EXEC;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                EXEC: begin
                    if (isBeq) begin
                        PCWr      = zero;
                        NPCOp     = 2'd1;
                        nextState = FETCH;
                    end else if (isLw || isSw) begin
                        nextState = MEM;
                    end else begin
                        nextState = WB;
                    end
                end
                MEM: begin
                    dmem_req = 1'b1;
                    MemWr    = isSw;
                    if (dmem_ack) begin
                        nextState = isLw ? WB : FETCH;
                    end else if (lastWait) begin
                        mem_err   = 1'b1;
                        nextState = FETCH;
                    end
                end
                WB: begin
                    RegWr     = 1'b1;
                    RegDst    = (isAddu || isSubu) ? 2'd1 : 2'd0;
                    WDSel     = isLw ? 2'd1 : 2'd0;
                    nextState = FETCH;
                end
                default: nextState = FETCH;
            endcase
        end
    end

    assign state = curState;

`ifdef MC_CTRL_PERF_EN
    // Free-running cycle count and retired-instruction count (aborted instructions excluded)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (curState != FETCH && nextState == FETCH && !illegal && !mem_err)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios plus randomized instruction stream against a per-cycle expectation list.
// Latency: one comparison per clock, sampled on the falling edge.
// Backpressure: dmem_ack wait lengths randomized, including timeouts.
module tb_mc_ctrl;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       PCWr, IRWr, RegWr, MemWr, dmem_req, ExtOp, ALUSrc, illegal, mem_err;
    logic [2:0] ALUOp, state;
    logic [1:0] RegDst, WDSel, NPCOp;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .dmem_ack(dmem_ack), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .dmem_req(dmem_req), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .RegDst(RegDst), .WDSel(WDSel), .NPCOp(NPCOp), .state(state),
        .illegal(illegal), .mem_err(mem_err)
    );

    // {state, PCWr, IRWr, RegWr, MemWr, dmem_req, ExtOp, ALUSrc, ALUOp, RegDst, WDSel, NPCOp, illegal, mem_err}
    logic [20:0] obsVec;
    assign obsVec = {state, PCWr, IRWr, RegWr, MemWr, dmem_req, ExtOp, ALUSrc,
                     ALUOp, RegDst, WDSel, NPCOp, illegal, mem_err};

    function automatic logic [20:0] mk(input logic [2:0] st, input logic [6:0] strb,
                                       input logic [2:0] aop, input logic [1:0] rd,
                                       input logic [1:0] wd, input logic [1:0] np,
                                       input logic ill, input logic me);
        return {st, strb, aop, rd, wd, np, ill, me};
    endfunction

    task automatic check(input string tag, input int cyc, input logic [20:0] expV);
        nTests++;
        assert (obsVec === expV) else begin
            nFail++;
            $error("FAIL %s c%0d observed=%h expected=%h", tag, cyc, obsVec, expV);
        end
    endtask

    // Builds the expected cycle-by-cycle trace of one instruction from the ISA rules, then
    // drives it. w = non-ack MEM cycles (w >= WAIT_MAX means timeout). stopAt >= 0 pulls
    // reset low partway through that cycle instead of finishing the instruction.
    task automatic runInstr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input int w, input logic zb, input int stopAt);
        logic [20:0] expQ[$];
        bit ackQ[$];
        bit zQ[$];
        bit rt, addu, subu, jr, nop, ori, lui, lw, sw, beq, j, jal, goesExec;
        logic ext, src;
        logic [2:0] aop;
        rt   = (op == 6'h00);
        addu = rt && fn == 6'h21;  subu = rt && fn == 6'h23;
        jr   = rt && fn == 6'h08;  nop  = rt && fn == 6'h00;
        ori  = op == 6'h0d;  lui = op == 6'h0f;  lw = op == 6'h23;  sw = op == 6'h2b;
        beq  = op == 6'h04;  j   = op == 6'h02;  jal = op == 6'h03;
        goesExec = addu || subu || ori || lui || lw || sw || beq;
        ext = lw || sw || beq;
        src = ori || lui || lw || sw;
        aop = subu ? 3'd1 : beq ? 3'd1 : ori ? 3'd2 : lui ? 3'd3 : 3'd0;

        expQ.push_back(mk(3'd0, 7'b1100000, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
        ackQ.push_back(bit'($urandom % 2)); zQ.push_back(bit'($urandom % 2));
        if (j)        expQ.push_back(mk(3'd1, 7'b1000000, 3'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0));
        else if (jal) expQ.push_back(mk(3'd1, 7'b1010000, 3'd0, 2'd2, 2'd2, 2'd2, 1'b0, 1'b0));
        else if (jr)  expQ.push_back(mk(3'd1, 7'b1000000, 3'd0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0));
        else          expQ.push_back(mk(3'd1, 7'b0000000, 3'd0, 2'd0, 2'd0, 2'd0,
                                        !goesExec && !nop, 1'b0));
        ackQ.push_back(bit'($urandom % 2)); zQ.push_back(bit'($urandom % 2));
        if (goesExec) begin
            expQ.push_back(mk(3'd2, {beq && zb, 4'b0000, ext, src}, aop, 2'd0, 2'd0,
                              beq ? 2'd1 : 2'd0, 1'b0, 1'b0));
            ackQ.push_back(bit'($urandom % 2)); zQ.push_back(beq ? zb : bit'($urandom % 2));
            if (lw || sw) begin
                int nWait = (w >= WAIT_MAX) ? WAIT_MAX : w;
                for (int k = 0; k < nWait; k++) begin
                    expQ.push_back(mk(3'd3, {3'b000, sw, 1'b1, ext, src}, aop, 2'd0, 2'd0, 2'd0,
                                      1'b0, (w >= WAIT_MAX) && (k == WAIT_MAX - 1)));
                    ackQ.push_back(1'b0); zQ.push_back(bit'($urandom % 2));
                end
                if (w < WAIT_MAX) begin
                    expQ.push_back(mk(3'd3, {3'b000, sw, 1'b1, ext, src}, aop, 2'd0, 2'd0, 2'd0,
                                      1'b0, 1'b0));
                    ackQ.push_back(1'b1); zQ.push_back(bit'($urandom % 2));
                end
            end
            if (addu || subu || ori || lui || (lw && w < WAIT_MAX)) begin
                expQ.push_back(mk(3'd4, {2'b00, 1'b1, 2'b00, ext, src}, aop,
                                  (addu || subu) ? 2'd1 : 2'd0, lw ? 2'd1 : 2'd0, 2'd0,
                                  1'b0, 1'b0));
                ackQ.push_back(bit'($urandom % 2)); zQ.push_back(bit'($urandom % 2));
            end
        end

        for (int c = 0; c < expQ.size(); c++) begin
            opcode   = op;
            funct    = fn;
            dmem_ack = ackQ[c];
            zero     = zQ[c];
            if (c == stopAt) begin
                #2 reset = 1'b0;
                #1 check({tag, "_rstnow"}, c, 21'd0);
                @(posedge clk); #1;
                check({tag, "_rsthold"}, c, 21'd0);
                reset = 1'b1;
                return;
            end
            @(negedge clk);
            check(tag, c, expQ[c]);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [5:0] illOps[4];
        illOps[0] = 6'h3f; illOps[1] = 6'h05; illOps[2] = 6'h08; illOps[3] = 6'h2a;

        // Reset state: everything low, state FETCH
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 0, 21'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed scenarios
        runInstr("ori",      6'h0d, 6'h00, 0, 1'b0, -1);
        runInstr("lw_w3",    6'h23, 6'h00, 3, 1'b0, -1);
        runInstr("lw_w0",    6'h23, 6'h00, 0, 1'b0, -1);
        runInstr("beq_z1",   6'h04, 6'h00, 0, 1'b1, -1);
        runInstr("beq_z0",   6'h04, 6'h00, 0, 1'b0, -1);
        runInstr("jal",      6'h03, 6'h00, 0, 1'b0, -1);
        runInstr("sw_tmo",   6'h2b, 6'h00, 99, 1'b0, -1);
        runInstr("lw_tmo",   6'h23, 6'h00, 99, 1'b0, -1);
        runInstr("sw_w14",   6'h2b, 6'h00, WAIT_MAX - 1, 1'b0, -1);
        runInstr("ill3f",    6'h3f, 6'h00, 0, 1'b0, -1);
        runInstr("illR",     6'h00, 6'h20, 0, 1'b0, -1);
        runInstr("nop",      6'h00, 6'h00, 0, 1'b0, -1);
        runInstr("jr",       6'h00, 6'h08, 0, 1'b0, -1);
        runInstr("addu",     6'h00, 6'h21, 0, 1'b0, -1);
        runInstr("lw_rst",   6'h23, 6'h00, 99, 1'b0, 5);
        runInstr("post_rst", 6'h00, 6'h23, 0, 1'b0, -1);

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            int sel;
            int w;
            logic [5:0] op;
            logic [5:0] fn;
            sel = $urandom_range(0, 12);
            w   = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 4);
            fn  = 6'($urandom);
            case (sel)
                0:  begin op = 6'h00; fn = 6'h21; end
                1:  begin op = 6'h00; fn = 6'h23; end
                2:  begin op = 6'h00; fn = 6'h08; end
                3:  begin op = 6'h00; fn = 6'h00; end
                4:  op = 6'h0d;
                5:  op = 6'h0f;
                6:  op = 6'h23;
                7:  op = 6'h2b;
                8:  op = 6'h04;
                9:  op = 6'h02;
                10: op = 6'h03;
                11: op = illOps[$urandom_range(0, 3)];
                default: begin op = 6'h00; fn = 6'h25; end
            endcase
            runInstr("rand", op, fn, w, 1'($urandom % 2), -1);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
